// File: rtl/button_conditioner.sv
// Conditions N raw active-low push-buttons into clean levels plus press, auto-repeat
// and release strobes. Each channel is fully independent (sync -> debounce -> repeat FSM).

module button_conditioner_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic rpt_o,
  output logic release_o
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LOAD  = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RP_W-1:0] PERIOD_LOAD = RP_W'(REPEAT_PERIOD - 1);
  localparam bit              RPT_ENABLED = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RPT,
    ST_HOLD
  } rpt_state_e;

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            rpt_q, rpt_d;
  logic            rel_q, rel_d;
  rpt_state_e      state_q, state_d;
  logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;

  logic raw_p;
  logic rise;
  logic fall;
  logic rp_zero;

  // Synchronisers idle at 1 so a reset looks like "released".
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign raw_p = ~sync2_q;

  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (raw_p == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
      rise     = ~level_q;
      fall     = level_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign rp_zero = (rp_cnt_q == '0);

  // Repeat FSM: state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      rp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
    end
  end

  // Repeat FSM: next state. A release always wins over a repeat that falls due on the same edge.
  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          if (RPT_ENABLED) begin
            state_d  = ST_ARMED;
            rp_cnt_d = DELAY_LOAD;
          end else begin
            state_d  = ST_HOLD;
          end
        end
      end
      ST_ARMED, ST_RPT: begin
        if (fall) begin
          state_d  = ST_IDLE;
          rp_cnt_d = '0;
        end else if (rp_zero) begin
          state_d  = ST_RPT;
          rp_cnt_d = PERIOD_LOAD;
        end else begin
          rp_cnt_d = rp_cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (fall) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        rp_cnt_d = '0;
      end
    endcase
  end

  // Repeat FSM: outputs.
  always_comb begin
    press_d = rise;
    rel_d   = fall;
    rpt_d   = ((state_q == ST_ARMED) || (state_q == ST_RPT)) && rp_zero && !fall;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rpt_q    <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rpt_q    <= rpt_d;
      rel_q    <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign rpt_o     = rpt_q;
  assign release_o = rel_q;

endmodule

module button_conditioner #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [N_BUTTONS-1:0] btn_n_i,
  input  logic                 enable_i,
  output logic [N_BUTTONS-1:0] level_o,
  output logic [N_BUTTONS-1:0] press_o,
  output logic [N_BUTTONS-1:0] rpt_o,
  output logic [N_BUTTONS-1:0] release_o
);

  logic [N_BUTTONS-1:0] press_raw;
  logic [N_BUTTONS-1:0] rpt_raw;
  logic [N_BUTTONS-1:0] rel_raw;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_conditioner_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .btn_n_i  (btn_n_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_raw[i]),
      .rpt_o    (rpt_raw[i]),
      .release_o(rel_raw[i])
    );
  end

  // Masking only the outputs keeps repeat timers in phase across enable changes.
  assign press_o   = press_raw & {N_BUTTONS{enable_i}};
  assign rpt_o     = rpt_raw   & {N_BUTTONS{enable_i}};
  assign release_o = rel_raw   & {N_BUTTONS{enable_i}};

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: vector table for debounce/bounce cases plus
// hand-written multi-cycle sequences for repeat, enable, reset and no-repeat behaviour.

module tb_button_conditioner;

  logic       clk;
  logic       reset_n;
  logic [3:0] btn_n, btn_nr;
  logic       enable;
  logic [3:0] level, press, rpt, rel;
  logic [3:0] level_nr, press_nr, rpt_nr, rel_nr;

  int checks = 0;
  int errors = 0;

  int lo_t[4];
  int hi_t[4];

  typedef struct {
    logic [3:0] btn;
    logic       en;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rp;
    logic [3:0] rls;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .N_BUTTONS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n), .btn_n_i(btn_n), .enable_i(enable),
    .level_o(level), .press_o(press), .rpt_o(rpt), .release_o(rel)
  );

  button_conditioner #(
    .N_BUTTONS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)
  ) dut_nr (
    .clk_i(clk), .reset_ni(reset_n), .btn_n_i(btn_nr), .enable_i(enable),
    .level_o(level_nr), .press_o(press_nr), .rpt_o(rpt_nr), .release_o(rel_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {level, press, rpt, rel};
  endfunction

  function automatic logic [15:0] outs_nr();
    return {level_nr, press_nr, rpt_nr, rel_nr};
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got lvl/prs/rpt/rel=%h want %h", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] b, input int n, input logic [3:0] l,
                     input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
    vec_t v;
    v.btn = b; v.en = 1'b1; v.lvl = l; v.prs = p; v.rp = r; v.rls = s;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic cfg(input int l0, input int h0, input int l1, input int h1,
                     input int l2, input int h2, input int l3, input int h3);
    lo_t[0] = l0; hi_t[0] = h0; lo_t[1] = l1; hi_t[1] = h1;
    lo_t[2] = l2; hi_t[2] = h2; lo_t[3] = l3; hi_t[3] = h3;
  endtask

  // Channel i is held low after tick lo and released after tick hi; the timing
  // model is press at lo+6, release at hi+6, repeats at P+20+8k while held.
  task automatic run_seq(input string name, input int nticks, input int en_from);
    for (int c = 0; c < nticks; c++) begin
      int t;
      logic [3:0] el, ep, er, es;
      logic en_now;
      for (int i = 0; i < 4; i++)
        btn_n[i] = !(lo_t[i] >= 0 && c >= lo_t[i] && c < hi_t[i]);
      en_now = (c + 1 >= en_from);
      enable = en_now;
      tick();
      t = c + 1;
      el = '0; ep = '0; er = '0; es = '0;
      for (int i = 0; i < 4; i++) begin
        if (lo_t[i] >= 0) begin
          int p, r;
          p = lo_t[i] + 6;
          r = hi_t[i] + 6;
          el[i] = (t >= p) && (t < r);
          ep[i] = (t == p);
          es[i] = (t == r);
          er[i] = (t >= p + 20) && (t < r) && (((t - p - 20) % 8) == 0);
        end
      end
      if (!en_now) begin
        ep = '0; er = '0; es = '0;
      end
      chk(name, t, outs(), {el, ep, er, es});
    end
    enable = 1'b1;
  endtask

  initial begin
    int pc, rc, sc;
    reset_n = 1'b0;
    btn_n   = 4'hF;
    btn_nr  = 4'hF;
    enable  = 1'b1;

    // Reset hold and quiet period.
    repeat (100) tick();
    chk("rst_hold", 0, outs(), 16'h0);
    chk("rst_hold_nr", 0, outs_nr(), 16'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("rst_quiet", k, outs(), 16'h0);
    end

    // Clean press on ch0 with 40+ cycle hold.
    cfg(0, 46, -1, -1, -1, -1, -1, -1);
    run_seq("clean_ch0", 60, 0);

    // Simultaneous ch1/ch3; ch1 release lands on its repeat edge and suppresses it.
    cfg(-1, -1, 0, 28, -1, -1, 0, 42);
    run_seq("simul_ch13", 56, 0);

    // Enable held low: level follows, no strobes.
    cfg(0, 30, -1, -1, -1, -1, -1, -1);
    run_seq("en_off", 44, 1000);

    // Enable rises mid-hold: no late press, repeats keep their phase.
    cfg(0, 40, -1, -1, -1, -1, -1, -1);
    run_seq("en_resume", 56, 30);

    // Bounce rejection and debounced press/release on ch2.
    add(4'b1011, 2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'b1111, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'b1011, 3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'b1111, 4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'b1011, 5, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'b1011, 1, 4'h4, 4'h4, 4'h0, 4'h0);
    add(4'b1011, 1, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'b1111, 3, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'b1011, 1, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'b1111, 5, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'b1111, 1, 4'h0, 4'h0, 4'h0, 4'h4);
    add(4'b1111, 3, 4'h0, 4'h0, 4'h0, 4'h0);
    foreach (vecs[k]) begin
      btn_n  = vecs[k].btn;
      enable = vecs[k].en;
      tick();
      chk("bounce_vec", k + 1, outs(), {vecs[k].lvl, vecs[k].prs, vecs[k].rp, vecs[k].rls});
    end

    // Reset in the middle of a held press.
    btn_n = 4'b1110;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 6) chk("mid_rst_press", k, outs(), {4'h1, 4'h1, 4'h0, 4'h0});
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_async", 0, outs(), 16'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("mid_rst_hold", k, outs(), 16'h0);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      logic [3:0] el, ep, es;
      tick();
      el = {3'b0, (k >= 6 && k < 13)};
      ep = {3'b0, (k == 6)};
      es = {3'b0, (k == 13)};
      chk("post_rst", k, outs(), {el, ep, 4'h0, es});
      if (k == 7) btn_n = 4'hF;
    end

    // No-repeat instance: 60-cycle hold gives one press and no repeats.
    pc = 0; rc = 0; sc = 0;
    btn_nr = 4'b1110;
    for (int t = 1; t <= 75; t++) begin
      tick();
      pc += $countones(press_nr);
      rc += $countones(rpt_nr);
      sc += $countones(rel_nr);
      if (t == 6)  chk("nr_press", t, outs_nr(), {4'h1, 4'h1, 4'h0, 4'h0});
      if (t == 66) chk("nr_release", t, outs_nr(), {4'h0, 4'h0, 4'h0, 4'h1});
      if (t == 60) btn_nr = 4'hF;
    end
    chk("nr_press_count", 0, 16'(pc), 16'd1);
    chk("nr_rpt_count", 0, 16'(rc), 16'd0);
    chk("nr_rel_count", 0, 16'(sc), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
